bcd_digitizer: RTL

Sequential binary-to-BCD converter that drives the four-digit seven-segment display driver's `hex0`–`hex3`/`dp` inputs. It accepts an unsigned binary value on a start strobe and runs an iterative shift-and-add-3 conversion, one bit per clock. It presents four BCD digits plus decimal-point enables. Outputs change only on completion, so the display never shows partial results.

---
 rtl/bcd_digitizer_if.sv | 47 ++++
 rtl/bcd_digitizer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bcd_digitizer_if.sv
// ---------------------------------------------------------------------------
// bcd_digitizer_if
//   Request/result bundle between a requester and bcd_digitizer.
//
//   Handshake: a request is accepted on the rising edge where start=1 and
//   ready=1; bin and dp_in are sampled on that same edge and may change
//   freely afterwards. start while ready=0 is dropped, never queued.
//   done_tick is a one-cycle pulse in the cycle the new hex*/dp/overflow
//   values first appear; those outputs hold until the next done_tick.
//
//   Signals:
//     start      requester -> digitizer  conversion request
//     bin[W]     requester -> digitizer  unsigned value to convert
//     dp_in[4]   requester -> digitizer  decimal-point enables, bit i = digit i
//     ready      digitizer -> requester  idle, request may be accepted
//     done_tick  digitizer -> requester  new result presented this cycle
//     hex0..hex3 digitizer -> requester  BCD digits, hex0 = units
//     dp[4]      digitizer -> requester  decimal points of the result
//     overflow   digitizer -> requester  value did not fit in four digits
//     state[2]   digitizer -> observer   current FSM state (0 idle, 1 op, 2 done)
// ---------------------------------------------------------------------------
interface bcd_digitizer_if #(
    parameter int W = 14
);
    logic         start;
    logic [W-1:0] bin;
    logic [3:0]   dp_in;
    logic         ready;
    logic         done_tick;
    logic [3:0]   hex0;
    logic [3:0]   hex1;
    logic [3:0]   hex2;
    logic [3:0]   hex3;
    logic [3:0]   dp;
    logic         overflow;
    logic [1:0]   state;

    modport master (
        output start, bin, dp_in,
        input  ready, done_tick, hex0, hex1, hex2, hex3, dp, overflow, state
    );

    modport slave (
        input  start, bin, dp_in,
        output ready, done_tick, hex0, hex1, hex2, hex3, dp, overflow, state
    );
endinterface

// File: rtl/bcd_digitizer.sv
// ---------------------------------------------------------------------------
// bcd_digitizer
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
//   feeding a four-digit seven-segment display driver. Results are only
//   published when a conversion completes, so the display never shows
//   partial digits.
//
//   Parameter:
//     W      width of bin, legal 4..16 (default 14)
//
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous active-high reset
//     bus    bcd_digitizer_if.slave: start/bin/dp_in in; ready, done_tick,
//            hex0..hex3, dp, overflow and debug state out
//
//   Optional feature (macro BCD_DIGITIZER_OVERFLOW_EN):
//     defined   -> a non-zero ten-thousands digit sets overflow and forces
//                  hex3..hex0 to E,E,E,E (dp still passed through)
//     undefined -> overflow is constant 0; hex3..hex0 show bin mod 10000
//
//   Latency W+1 cycles from the accepting edge; one conversion per W+2.
// ---------------------------------------------------------------------------
module bcd_digitizer #(
    parameter int W = 14
) (
    input  logic                clk,
    input  logic                reset,
    bcd_digitizer_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;

    logic [W-1:0] shift_reg;
    logic [19:0]  bcd;          // five BCD digits, digit 4 internal only
    logic [3:0]   cnt;
    logic [3:0]   dp_lat;

    logic [15:0]  hex_reg;
    logic [3:0]   dp_reg;
    logic         done_reg;

    logic [18:0]  adj;          // add-3 adjusted digits; top bit shifts out
    logic [19:0]  bcd_next;
    logic [W-1:0] shift_next;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = OP;
            OP:      if (cnt == 4'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- add-3 and shift ----------------
    // Digits are adjusted independently: a digit <= 9 plus 3 stays <= 12,
    // so no carry ever crosses a digit boundary.
    always_comb begin
        adj = '0;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            else                       adj[4*i +: 4] = bcd[4*i +: 4];
        end
        // Digit 4 never reaches 8 before its final shift, so its MSB after
        // adjustment is always shifted out; only three bits are kept.
        if (bcd[19:16] >= 4'd5) adj[18:16] = 3'(bcd[19:16] + 4'd3);
        else                    adj[18:16] = bcd[18:16];
        bcd_next   = {adj, shift_reg[W-1]};
        shift_next = {shift_reg[W-2:0], 1'b0};
    end

    // ---------------- datapath ----------------
`ifdef BCD_DIGITIZER_OVERFLOW_EN
    logic ovf_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            bcd       <= '0;
            cnt       <= '0;
            dp_lat    <= '0;
            hex_reg   <= '0;
            dp_reg    <= '0;
            done_reg  <= 1'b0;
`ifdef BCD_DIGITIZER_OVERFLOW_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shift_reg <= bus.bin;
                        bcd       <= '0;
                        dp_lat    <= bus.dp_in;
                        cnt       <= 4'(W - 1);
                    end
                end
                OP: begin
                    shift_reg <= shift_next;
                    bcd       <= bcd_next;
                    cnt       <= cnt - 4'd1;
                end
                DONE: begin
                    done_reg <= 1'b1;
                    dp_reg   <= dp_lat;
`ifdef BCD_DIGITIZER_OVERFLOW_EN
                    if (bcd[19:16] != 4'd0) begin
                        ovf_reg <= 1'b1;
                        hex_reg <= 16'hEEEE;
                    end else begin
                        ovf_reg <= 1'b0;
                        hex_reg <= bcd[15:0];
                    end
`else
                    hex_reg  <= bcd[15:0];
`endif
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign bus.ready     = (state == IDLE);
    assign bus.done_tick = done_reg;
    assign bus.hex0      = hex_reg[3:0];
    assign bus.hex1      = hex_reg[7:4];
    assign bus.hex2      = hex_reg[11:8];
    assign bus.hex3      = hex_reg[15:12];
    assign bus.dp        = dp_reg;
    assign bus.state     = state;
`ifdef BCD_DIGITIZER_OVERFLOW_EN
    assign bus.overflow  = ovf_reg;
`else
    assign bus.overflow  = 1'b0;
`endif

endmodule
